// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle RISC-V sequencing controller:
// FSM state encoding, supported opcodes, and the select/operation codes
// that the controller presents to the datapath and ALU decoder.
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   // Immediate format follows the opcode alone; R-type and unknown
   // opcodes fall back to the I format since nothing consumes it.
   function automatic logic [1:0] immSrcFor(input logic [6:0] op);
      case (op)
         OP_SW:   immSrcFor = IMM_S;
         OP_BEQ:  immSrcFor = IMM_B;
         OP_JAL:  immSrcFor = IMM_J;
         default: immSrcFor = IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the
// datapath (slave). The instret counter only exists when
// MULTICYCLE_INSTRET_EN is defined.
interface multicycle_control_if;

   logic [6:0] Op;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       Zero;
   logic       mem_ready;

   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic [2:0] Selection;
   logic       illegal;
`ifdef MULTICYCLE_INSTRET_EN
   logic [31:0] instret;
`endif

   modport master (
      input  Op, funct3, funct7, Zero, mem_ready,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
      output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, Selection, illegal
`ifdef MULTICYCLE_INSTRET_EN
      , output instret
`endif
   );

   modport slave (
      output Op, funct3, funct7, Zero, mem_ready,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
      input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, Selection, illegal
`ifdef MULTICYCLE_INSTRET_EN
      , input instret
`endif
   );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: turns the controller's ALUOp plus the instruction's
// funct fields into the 3-bit ALU Selection. Only Op[5] and funct7[5]
// matter, so only those bits are brought in.
module alu_decoder
   import multicycle_pkg::*;
(
   input  aluop_t     ALUOp,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] Selection
);

   // Fixed add/sub for address and branch work, funct3 decode otherwise;
   // an unimplemented funct3 (011) falls back to add.
   always_comb begin
      Selection = ALU_ADD;
      case (ALUOp)
         ALUOP_ADD: Selection = ALU_ADD;
         ALUOP_SUB: Selection = ALU_SUB;
         default: begin
            case (funct3)
               3'b000:  Selection = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  Selection = ALU_SLL;
               3'b010:  Selection = ALU_SLT;
               3'b100:  Selection = ALU_XOR;
               3'b101:  Selection = ALU_SRL;
               3'b110:  Selection = ALU_OR;
               3'b111:  Selection = ALU_AND;
               default: Selection = ALU_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V sequencing controller: a Moore FSM stepping the
// shared ALU, unified memory port, IR, PC and register file through
// lw/sw/R/I/beq/jal, stalling on mem_ready in FETCH, MEMREAD, MEMWRITE.
// Optional feature: define MULTICYCLE_INSTRET_EN to add the 32-bit
// retired-instruction counter output instret.
module multicycle_control
   import multicycle_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_control_if.master bus
);

   state_t     state;
   state_t     nextState;
   aluop_t     aluOp;
   logic       pcUpdate;
   logic       branch;
   logic       irWrite;
   logic [2:0] selection;

   // State register; reset drops straight back to FETCH, abandoning
   // whatever instruction was in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= nextState;
   end

   // Next-state sequencing: memory states wait for mem_ready, DECODE
   // dispatches on the opcode and sends unknown ones back to FETCH.
   always_comb begin
      nextState = state;
      case (state)
         S_FETCH:    if (bus.mem_ready) nextState = S_DECODE;
         S_DECODE: begin
            case (bus.Op)
               OP_LW, OP_SW: nextState = S_MEMADR;
               OP_R:         nextState = S_EXECR;
               OP_I:         nextState = S_EXECI;
               OP_BEQ:       nextState = S_BEQ;
               OP_JAL:       nextState = S_JAL;
               default:      nextState = S_FETCH;
            endcase
         end
         S_MEMADR:   nextState = (bus.Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (bus.mem_ready) nextState = S_MEMWB;
         S_MEMWB:    nextState = S_FETCH;
         S_MEMWRITE: if (bus.mem_ready) nextState = S_FETCH;
         S_EXECR:    nextState = S_ALUWB;
         S_EXECI:    nextState = S_ALUWB;
         S_ALUWB:    nextState = S_FETCH;
         S_BEQ:      nextState = S_FETCH;
         S_JAL:      nextState = S_ALUWB;
         default:    nextState = S_FETCH;
      endcase
   end

   // Per-state control outputs; FETCH's IR/PC update waits on mem_ready
   // and is also held off while reset is asserted.
   always_comb begin
      aluOp         = ALUOP_ADD;
      pcUpdate      = 1'b0;
      branch        = 1'b0;
      irWrite       = 1'b0;
      bus.AdrSrc    = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.RegWrite  = 1'b0;
      bus.ResultSrc = RES_ALUOUT;
      bus.ALUSrcA   = SRCA_PC;
      bus.ALUSrcB   = SRCB_RS2;
      bus.illegal   = 1'b0;
      case (state)
         S_FETCH: begin
            bus.ALUSrcB   = SRCB_FOUR;
            bus.ResultSrc = RES_ALURESULT;
            irWrite       = bus.mem_ready & rst_n;
            pcUpdate      = bus.mem_ready & rst_n;
         end
         S_DECODE: begin
            bus.ALUSrcA = SRCA_OLDPC;
            bus.ALUSrcB = SRCB_IMM;
            case (bus.Op)
               OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: bus.illegal = 1'b0;
               default:                                  bus.illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            bus.ALUSrcA = SRCA_RS1;
            bus.ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: begin
            bus.AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            bus.ResultSrc = RES_DATA;
            bus.RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            bus.AdrSrc   = 1'b1;
            bus.MemWrite = 1'b1;
         end
         S_EXECR: begin
            bus.ALUSrcA = SRCA_RS1;
            aluOp       = ALUOP_FUNCT;
         end
         S_EXECI: begin
            bus.ALUSrcA = SRCA_RS1;
            bus.ALUSrcB = SRCB_IMM;
            aluOp       = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            bus.RegWrite = 1'b1;
         end
         S_BEQ: begin
            bus.ALUSrcA = SRCA_RS1;
            aluOp       = ALUOP_SUB;
            branch      = 1'b1;
         end
         S_JAL: begin
            bus.ALUSrcA = SRCA_OLDPC;
            bus.ALUSrcB = SRCB_FOUR;
            pcUpdate    = 1'b1;
         end
         default: begin
            aluOp = ALUOP_ADD;
         end
      endcase
   end

   // Glue: PC enable merges unconditional update with taken branch.
   always_comb begin
      bus.PCWrite   = pcUpdate | (branch & bus.Zero);
      bus.IRWrite   = irWrite;
      bus.ImmSrc    = immSrcFor(bus.Op);
      bus.Selection = selection;
   end

   alu_decoder u_aluDecoder (
      .ALUOp     (aluOp),
      .funct3    (bus.funct3),
      .op5       (bus.Op[5]),
      .funct7b5  (bus.funct7[5]),
      .Selection (selection)
   );

`ifdef MULTICYCLE_INSTRET_EN
   logic [31:0] instretCount;
   logic        retiring;

   // An instruction retires on its last cycle before FETCH; illegal
   // opcodes leave from DECODE and are deliberately not counted.
   always_comb begin
      retiring = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                 ((state == S_MEMWRITE) && bus.mem_ready);
   end

   // Free-running 32-bit retire counter, wrapping naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        instretCount <= 32'd0;
      else if (retiring) instretCount <= instretCount + 32'd1;
   end

   assign bus.instret = instretCount;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is
// expanded into its list of phases, with optional memory stalls, and
// every cycle's outputs are compared with values taken from the
// per-phase control table. Define MULTICYCLE_INSTRET_EN to also check
// the retire counter.
module tb_multicycle_control;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BQ  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;

   typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_XR, P_XI, P_WB, P_BEQ, P_JAL} phase_t;

   typedef struct packed {
      logic       pcw, adr, memw, irw, regw, ill;
      logic [1:0] res, srcA, srcB;
      logic [2:0] sel;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   passed = 0;
   int   modelInstret = 0;

   always #5 clk = ~clk;

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed === expected) passed++;
      else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   function automatic bit isLegal(input logic [6:0] op);
      return (op == LW) || (op == SW) || (op == RT) || (op == IT) || (op == BQ) || (op == JL);
   endfunction

   function automatic logic [1:0] immFor(input logic [6:0] op);
      if (op == SW) return 2'b01;
      if (op == BQ) return 2'b10;
      if (op == JL) return 2'b11;
      return 2'b00;
   endfunction

   // ALU operation an R/I instruction asks for, by funct3 meaning.
   function automatic logic [2:0] aluFunc(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      case (f3)
         3'd0:    return (op[5] && f7[5]) ? 3'd1 : 3'd0;
         3'd1:    return 3'd6;
         3'd2:    return 3'd5;
         3'd4:    return 3'd4;
         3'd5:    return 3'd7;
         3'd6:    return 3'd3;
         3'd7:    return 3'd2;
         default: return 3'd0;
      endcase
   endfunction

   // Control table per phase; anything not mentioned is zero.
   function automatic exp_t expectFor(input phase_t ph, input bit rdy, input bit zero,
                                      input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      exp_t e;
      e = '0;
      case (ph)
         P_F:   begin e.srcB = 2'd2; e.res = 2'd2; e.irw = rdy; e.pcw = rdy; end
         P_D:   begin e.srcA = 2'd1; e.srcB = 2'd1; e.ill = !isLegal(op); end
         P_MA:  begin e.srcA = 2'd2; e.srcB = 2'd1; end
         P_MR:  begin e.adr = 1'b1; end
         P_MWB: begin e.res = 2'd1; e.regw = 1'b1; end
         P_MW:  begin e.adr = 1'b1; e.memw = 1'b1; end
         P_XR:  begin e.srcA = 2'd2; e.sel = aluFunc(op, f3, f7); end
         P_XI:  begin e.srcA = 2'd2; e.srcB = 2'd1; e.sel = aluFunc(op, f3, f7); end
         P_WB:  begin e.regw = 1'b1; end
         P_BEQ: begin e.srcA = 2'd2; e.sel = 3'd1; e.pcw = zero; end
         P_JAL: begin e.srcA = 2'd1; e.srcB = 2'd2; e.pcw = 1'b1; end
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic checkCycle(input string ph, input exp_t e, input logic [1:0] imm);
      checkOutput({ph, ".PCWrite"},   {31'd0, bus.PCWrite},   {31'd0, e.pcw});
      checkOutput({ph, ".AdrSrc"},    {31'd0, bus.AdrSrc},    {31'd0, e.adr});
      checkOutput({ph, ".MemWrite"},  {31'd0, bus.MemWrite},  {31'd0, e.memw});
      checkOutput({ph, ".IRWrite"},   {31'd0, bus.IRWrite},   {31'd0, e.irw});
      checkOutput({ph, ".RegWrite"},  {31'd0, bus.RegWrite},  {31'd0, e.regw});
      checkOutput({ph, ".illegal"},   {31'd0, bus.illegal},   {31'd0, e.ill});
      checkOutput({ph, ".ResultSrc"}, {30'd0, bus.ResultSrc}, {30'd0, e.res});
      checkOutput({ph, ".ALUSrcA"},   {30'd0, bus.ALUSrcA},   {30'd0, e.srcA});
      checkOutput({ph, ".ALUSrcB"},   {30'd0, bus.ALUSrcB},   {30'd0, e.srcB});
      checkOutput({ph, ".Selection"}, {29'd0, bus.Selection}, {29'd0, e.sel});
      checkOutput({ph, ".ImmSrc"},    {30'd0, bus.ImmSrc},    {30'd0, imm});
`ifdef MULTICYCLE_INSTRET_EN
      checkOutput({ph, ".instret"},   bus.instret,            modelInstret);
`endif
   endtask

   // Runs one instruction from FETCH to its last phase. A stall count of
   // -1 picks a random number of not-ready cycles (0..3).
   task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input int fetchStalls, input int memStalls, input bit zero);
      phase_t q[$];
      int     st;
      bit     rdy;
      bit     waits;
      exp_t   e;
      q = {P_F, P_D};
      if (op == LW)      q = {q, P_MA, P_MR, P_MWB};
      else if (op == SW) q = {q, P_MA, P_MW};
      else if (op == RT) q = {q, P_XR, P_WB};
      else if (op == IT) q = {q, P_XI, P_WB};
      else if (op == BQ) q = {q, P_BEQ};
      else if (op == JL) q = {q, P_JAL, P_WB};
      for (int p = 0; p < q.size(); p++) begin
         waits = (q[p] == P_F) || (q[p] == P_MR) || (q[p] == P_MW);
         st = 0;
         if (q[p] == P_F) st = (fetchStalls < 0) ? int'($urandom_range(0, 3)) : fetchStalls;
         else if (waits)  st = (memStalls < 0) ? int'($urandom_range(0, 3)) : memStalls;
         for (int s = 0; s <= st; s++) begin
            @(negedge clk);
            if (p == 0 && s == 0) begin
               bus.Op     = op;
               bus.funct3 = f3;
               bus.funct7 = f7;
            end
            rdy = waits ? (s == st) : 1'($urandom_range(0, 1));
            bus.mem_ready = rdy;
            bus.Zero      = (q[p] == P_BEQ) ? zero : 1'($urandom_range(0, 1));
            #1;
            e = expectFor(q[p], rdy, bus.Zero, op, f3, f7);
            checkCycle(q[p].name(), e, immFor(op));
         end
      end
      if (isLegal(op)) modelInstret++;
   endtask

   initial begin
      logic [6:0] op;
      logic [6:0] legalOps [6];
      rst_n         = 1'b0;
      bus.mem_ready = 1'b1;
      bus.Zero      = 1'b0;
      bus.Op        = 7'd0;
      bus.funct3    = 3'd0;
      bus.funct7    = 7'd0;
      legalOps      = '{LW, SW, RT, IT, BQ, JL};

      #2;
      checkOutput("rst.IRWrite",  {31'd0, bus.IRWrite},  32'd0);
      checkOutput("rst.PCWrite",  {31'd0, bus.PCWrite},  32'd0);
      checkOutput("rst.MemWrite", {31'd0, bus.MemWrite}, 32'd0);
      checkOutput("rst.RegWrite", {31'd0, bus.RegWrite}, 32'd0);
      checkOutput("rst.ALUSrcB",  {30'd0, bus.ALUSrcB},  32'd2);
      checkOutput("rst.ResultSrc",{30'd0, bus.ResultSrc},32'd2);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      rst_n = 1'b1;

      // Directed cases: add, sub, addi with funct7[5] set, stalled lw,
      // sw, beq taken/not taken, jal, illegal opcode.
      applyStimulus(RT, 3'd0, 7'h00, 0, 0, 1'b0);
      applyStimulus(RT, 3'd0, 7'h20, 0, 0, 1'b0);
      applyStimulus(IT, 3'd0, 7'h20, 0, 0, 1'b0);
      applyStimulus(LW, 3'd2, 7'h00, 0, 3, 1'b0);
      applyStimulus(SW, 3'd2, 7'h00, 0, 0, 1'b0);
      applyStimulus(BQ, 3'd0, 7'h00, 0, 0, 1'b1);
      applyStimulus(BQ, 3'd0, 7'h00, 0, 0, 1'b0);
      applyStimulus(JL, 3'd0, 7'h00, 0, 0, 1'b0);
      applyStimulus(7'b1111111, 3'd0, 7'h00, 0, 0, 1'b0);
      applyStimulus(SW, 3'd2, 7'h00, 2, 2, 1'b0);

      // Randomized instruction stream, roughly one in seven illegal.
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 6) == 0) begin
            op = 7'($urandom);
            while (isLegal(op)) op = 7'($urandom);
         end else begin
            op = legalOps[$urandom_range(0, 5)];
         end
         applyStimulus(op, 3'($urandom), 7'($urandom), -1, -1, 1'($urandom));
      end

      // Reset while MEMWRITE is stalled: write must vanish at once.
      @(negedge clk);
      bus.Op = SW; bus.funct3 = 3'd2; bus.mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      checkOutput("mw.MemWrite", {31'd0, bus.MemWrite}, 32'd1);
      checkOutput("mw.AdrSrc",   {31'd0, bus.AdrSrc},   32'd1);
      #1;
      rst_n = 1'b0;
      bus.mem_ready = 1'b1;
      #1;
      modelInstret = 0;
      checkOutput("midrst.MemWrite", {31'd0, bus.MemWrite}, 32'd0);
      checkOutput("midrst.IRWrite",  {31'd0, bus.IRWrite},  32'd0);
      checkOutput("midrst.PCWrite",  {31'd0, bus.PCWrite},  32'd0);
      checkOutput("midrst.AdrSrc",   {31'd0, bus.AdrSrc},   32'd0);
      checkOutput("midrst.ALUSrcB",  {30'd0, bus.ALUSrcB},  32'd2);
`ifdef MULTICYCLE_INSTRET_EN
      checkOutput("midrst.instret",  bus.instret,           32'd0);
`endif
      @(negedge clk);
      bus.mem_ready = 1'b0;
      rst_n = 1'b1;
      #1;
      checkOutput("rel.IRWrite", {31'd0, bus.IRWrite}, 32'd0);
      checkOutput("rel.ALUSrcB", {30'd0, bus.ALUSrcB}, 32'd2);
      applyStimulus(RT, 3'd7, 7'h00, 1, 0, 1'b0);
      applyStimulus(LW, 3'd2, 7'h00, 0, 0, 1'b0);

      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
